// File: rtl/gpr_wb_if.sv
// rtl/gpr_wb_if.sv - writeback arbiter bus bundle (ALU stream, load stream, register file write port, busy)
//
// Purpose: groups every signal between the execute/memory stages, the
// writeback arbiter and the register file write port.
// Signals:
//   alu_valid/alu_dest/alu_data       ALU result stream (never stalled)
//   ld_valid/ld_ready/ld_dest/ld_data load result stream (valid/ready)
//   reg_write_en/dest/data            registered register file write port
//   busy[7:0]                         per-register pending-load scoreboard
// Modports:
//   slave  - the arbiter side
//   master - the producer / register file side
interface gpr_wb_if #(
  parameter int DATA_WIDTH = 15
);
  logic                  alu_valid;
  logic [2:0]            alu_dest;
  logic [DATA_WIDTH:0]   alu_data;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [2:0]            ld_dest;
  logic [DATA_WIDTH:0]   ld_data;
  logic                  reg_write_en;
  logic [2:0]            reg_write_dest;
  logic [DATA_WIDTH:0]   reg_write_data;
  logic [7:0]            busy;

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  ld_valid, ld_dest, ld_data,
    output ld_ready,
    output reg_write_en, reg_write_dest, reg_write_data,
    output busy
  );

  modport master (
    output alu_valid, alu_dest, alu_data,
    output ld_valid, ld_dest, ld_data,
    input  ld_ready,
    input  reg_write_en, reg_write_dest, reg_write_data,
    input  busy
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - GPR writeback arbiter merging ALU results with a queued load stream
//
// Purpose: drives the single register file write port. ALU results always
// win and are written one cycle later; load results wait in an in-order
// circular queue of DEPTH entries. An ALU write to register d cancels every
// queued load to d (it is newer), so write-after-write order is preserved.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    gpr_wb_if.slave (ALU stream, load stream, write port, busy)
// Parameters:
//   DATA_WIDTH  MSB index of the data buses
//   DEPTH       load queue entries (power of two, 2..8)
// Build option:
//   GPR_WB_ZERO_REG_EN  register 0 is hardwired zero; writes to it are dropped
module gpr_wb_arbiter #(
  parameter int DATA_WIDTH = 15,
  parameter int DEPTH      = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  gpr_wb_if.slave   bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]          q_dest [DEPTH];
  logic [DATA_WIDTH:0] q_data [DEPTH];
  logic [DEPTH-1:0]    q_live;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [CW-1:0]       count;

  logic alu_eff;
  logic ld_acc;
  logic ld_enq;
  logic head_live;
  logic pop;
  logic enq_live;
  logic [7:0] busy_c;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign bus.ld_ready = (count < CW'(DEPTH)) & rst_n;
  assign ld_acc       = bus.ld_valid & bus.ld_ready;

`ifdef GPR_WB_ZERO_REG_EN
  // Register 0 is constant: ALU writes to it vanish (and kill nothing);
  // loads to it complete the handshake but are never queued.
  assign alu_eff = bus.alu_valid & (bus.alu_dest != 3'd0);
  assign ld_enq  = ld_acc & (bus.ld_dest != 3'd0);
`else
  assign alu_eff = bus.alu_valid;
  assign ld_enq  = ld_acc;
`endif

  assign head_live = (count != '0) & q_live[rd_ptr];
  // A dead head drains even while the ALU owns the port; a live head only
  // leaves when it actually gets the write port.
  assign pop       = (count != '0) & (~head_live | ~alu_eff);
  // A load arriving with a same-cycle ALU write to the same register is the
  // older of the two, so it enters the queue already dead.
  assign enq_live  = ~(alu_eff & (bus.ld_dest == bus.alu_dest));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr             <= '0;
      wr_ptr             <= '0;
      count              <= '0;
      q_live             <= '0;
      bus.reg_write_en   <= 1'b0;
      bus.reg_write_dest <= 3'd0;
      bus.reg_write_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_dest[i] <= 3'd0;
        q_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_eff && (q_dest[i] == bus.alu_dest))
          q_live[i] <= 1'b0;
      end

      // Clearing live on pop keeps busy limited to occupied slots.
      if (pop) begin
        q_live[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + PW'(1);
      end

      // Push never targets the popped slot: push needs count<DEPTH and pop
      // needs count>0, so wr_ptr==rd_ptr cannot coincide with both.
      if (ld_enq) begin
        q_dest[wr_ptr] <= bus.ld_dest;
        q_data[wr_ptr] <= bus.ld_data;
        q_live[wr_ptr] <= enq_live;
        wr_ptr         <= wr_ptr + PW'(1);
      end

      count <= count + {{(CW-1){1'b0}}, ld_enq} - {{(CW-1){1'b0}}, pop};

      if (alu_eff) begin
        bus.reg_write_en   <= 1'b1;
        bus.reg_write_dest <= bus.alu_dest;
        bus.reg_write_data <= bus.alu_data;
      end else if (head_live) begin
        bus.reg_write_en   <= 1'b1;
        bus.reg_write_dest <= q_dest[rd_ptr];
        bus.reg_write_data <= q_data[rd_ptr];
      end else begin
        bus.reg_write_en   <= 1'b0;
      end
    end
  end

  // Scoreboard of registers with a pending load, from registered state only.
  always_comb begin
    busy_c = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i])
        busy_c[q_dest[i]] = 1'b1;
    end
  end

  assign bus.busy = busy_c;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb/tb_gpr_wb_arbiter.sv - self-checking bench for gpr_wb_arbiter
module tb_gpr_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic [2:0]  dest;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  wr_t sb[$];

  gpr_wb_if #(.DATA_WIDTH(15)) bus();

  gpr_wb_arbiter #(.DATA_WIDTH(15), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
  endtask

  task automatic expect_wr(input logic [2:0] d, input logic [15:0] v, input int at);
    wr_t w;
    w.dest = d;
    w.data = v;
    w.cyc  = at;
    sb.push_back(w);
  endtask

  task automatic drive_alu(input logic [2:0] d, input logic [15:0] v);
    bus.alu_valid = 1'b1;
    bus.alu_dest  = d;
    bus.alu_data  = v;
  endtask

  task automatic drive_ld(input logic [2:0] d, input logic [15:0] v);
    bus.ld_valid = 1'b1;
    bus.ld_dest  = d;
    bus.ld_data  = v;
  endtask

  // Every write the port produces must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.reg_write_en === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_write", 32'(bus.reg_write_dest), 32'hffff_ffff);
      end else begin
        wr_t w;
        w = sb.pop_front();
        check_eq("wr_dest", 32'(bus.reg_write_dest), 32'(w.dest));
        check_eq("wr_data", 32'(bus.reg_write_data), 32'(w.data));
        check_eq("wr_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    bus.ld_dest = 3'd0;
    bus.ld_data = 16'h0;

    // Reset held with ALU active.
    drive_alu(3'd3, 16'hdead);
    step();
    step();
    check_eq("rst_en", 32'(bus.reg_write_en), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_ready", 32'(bus.ld_ready), 32'd0);
    rst_n = 1'b1;
    idle();
    step();
    check_eq("rel_ready", 32'(bus.ld_ready), 32'd1);
    check_eq("rel_en", 32'(bus.reg_write_en), 32'd0);

    // ALU only, latency 1.
    drive_alu(3'd3, 16'h1234);
    expect_wr(3'd3, 16'h1234, cyc + 1);
    step();
    check_eq("alu_en", 32'(bus.reg_write_en), 32'd1);
    idle();
    step();
    check_eq("alu_idle_en", 32'(bus.reg_write_en), 32'd0);

    // Queue fill while ALU owns the port every cycle.
    drive_alu(3'd6, 16'h0101);
    drive_ld(3'd1, 16'h1111);
    expect_wr(3'd6, 16'h0101, cyc + 1);
    step();
    check_eq("fill1_busy", 32'(bus.busy), 32'h02);
    check_eq("fill1_ready", 32'(bus.ld_ready), 32'd1);
    drive_alu(3'd7, 16'h0202);
    drive_ld(3'd2, 16'h2222);
    expect_wr(3'd7, 16'h0202, cyc + 1);
    step();
    check_eq("fill2_busy", 32'(bus.busy), 32'h06);
    check_eq("fill2_ready", 32'(bus.ld_ready), 32'd0);
    drive_alu(3'd6, 16'h0303);
    drive_ld(3'd3, 16'h3333);   // refused: queue full
    expect_wr(3'd6, 16'h0303, cyc + 1);
    step();
    check_eq("full_busy", 32'(bus.busy), 32'h06);
    check_eq("full_ready", 32'(bus.ld_ready), 32'd0);
    idle();
    expect_wr(3'd1, 16'h1111, cyc + 1);
    step();
    check_eq("drain1_ready", 32'(bus.ld_ready), 32'd1);
    check_eq("drain1_busy", 32'(bus.busy), 32'h04);
    expect_wr(3'd2, 16'h2222, cyc + 1);
    step();
    check_eq("drain2_busy", 32'(bus.busy), 32'h00);
    step();
    check_eq("drain_idle_en", 32'(bus.reg_write_en), 32'd0);

    // WAW kill: queued load overtaken by a newer ALU write.
    drive_ld(3'd5, 16'haaaa);
    step();
    check_eq("waw_busy_set", 32'(bus.busy), 32'h20);
    idle();
    drive_alu(3'd5, 16'h5555);
    expect_wr(3'd5, 16'h5555, cyc + 1);
    step();
    check_eq("waw_busy_clr", 32'(bus.busy), 32'h00);
    idle();
    step();
    check_eq("waw_dead_pop_en", 32'(bus.reg_write_en), 32'd0);
    step();
    check_eq("waw_after_en", 32'(bus.reg_write_en), 32'd0);
    check_eq("waw_ready", 32'(bus.ld_ready), 32'd1);

    // Same-cycle load and ALU to the same register: load is older and dies.
    drive_alu(3'd4, 16'h4444);
    drive_ld(3'd4, 16'h9999);
    expect_wr(3'd4, 16'h4444, cyc + 1);
    step();
    check_eq("same_busy", 32'(bus.busy), 32'h00);
    idle();
    step();
    check_eq("same_pop_en", 32'(bus.reg_write_en), 32'd0);
    step();

    // Register 0 handling.
    drive_alu(3'd0, 16'h0bad);
`ifndef GPR_WB_ZERO_REG_EN
    expect_wr(3'd0, 16'h0bad, cyc + 1);
`endif
    step();
    idle();
    check_eq("r0_ready", 32'(bus.ld_ready), 32'd1);
    drive_ld(3'd0, 16'h0ace);
    step();
    idle();
`ifdef GPR_WB_ZERO_REG_EN
    check_eq("r0_busy", 32'(bus.busy), 32'h00);
    step();
    check_eq("r0_ld_en", 32'(bus.reg_write_en), 32'd0);
`else
    check_eq("r0_busy", 32'(bus.busy), 32'h01);
    expect_wr(3'd0, 16'h0ace, cyc + 1);
    step();
    check_eq("r0_ld_en", 32'(bus.reg_write_en), 32'd1);
`endif
    step();

    // Reset mid-operation discards queued loads.
    drive_alu(3'd1, 16'h7777);
    drive_ld(3'd2, 16'h8888);
    expect_wr(3'd1, 16'h7777, cyc + 1);
    step();
    idle();
    rst_n = 1'b0;
    step();
    check_eq("midrst_busy", 32'(bus.busy), 32'h00);
    check_eq("midrst_en", 32'(bus.reg_write_en), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    step();
    check_eq("midrst_ready", 32'(bus.ld_ready), 32'd1);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gpr_wb_arbiter.md
# gpr_wb_arbiter

Writeback arbiter that initiates all writes into the 8-entry general-purpose register file through its single write port. Merges a non-stallable ALU result stream with a valid/ready load-result stream. Load results are buffered in a small in-order queue. Write-after-write order is kept by cancelling queued load results that a newer ALU write overtakes. Sits between execute/memory stages and the register file write port.

## Interface
- DATA_WIDTH, 15, MSB index of data; all data buses are DATA_WIDTH+1 bits (16), matching the register file
- DEPTH, 2, load queue entries (power of two, 2..8)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- alu_valid  in  1  ALU result present this cycle; never stalled
- alu_dest  in  3  ALU destination register
- alu_data  in  DATA_WIDTH+1  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load queue can accept
- ld_dest  in  3  load destination register
- ld_data  in  DATA_WIDTH+1  load result
- reg_write_en  out  1  register file write enable (registered)
- reg_write_dest  out  3  register file write address (registered)
- reg_write_data  out  DATA_WIDTH+1  register file write data (registered)
- busy  out  8  bit d = 1 while a live queued load targets register d

## Operation
- Load accepted on a cycle with ld_valid & ld_ready; pushed to queue tail with live=1.
- ld_ready = (count < DEPTH) & rst_n. It depends on registered count only, so there is no push into a full queue even if a pop occurs that cycle.
- Each cycle the write stage selects one source:
  - if alu_valid: ALU result
  - else if queue head is live: head is popped and written
  - else: no write (reg_write_en=0 next cycle)
- Kill rule: on alu_valid with dest d, every queued entry with dest d becomes live=0. This includes a load accepted in the same cycle, which counts as older.
- A dead head entry is popped in any cycle, including while ALU is writing, with no write produced.
- busy is derived from registered queue state: OR of live entries' one-hot dests.
- Queue is circular: rd/wr pointers wrap modulo DEPTH; count 0..DEPTH.
- Reset (rst_n=0 at edge) clears:
  - queue: count=0, all live=0, pointers 0
  - reg_write_en=0, reg_write_dest=0, reg_write_data=0
- Reset mid-operation discards queued loads without writing them.

## Timing
- ALU: alu_valid at cycle N -> reg_write_en=1 with that dest/data during N+1. Fixed latency 1.
- Load: accepted at N, queue idle, no ALU at N+1 -> write during N+2. Minimum latency 2.
- Each cycle an ALU request is present delays a live queued load by 1 cycle.
- Write port carries at most one write per cycle; back-to-back writes are allowed.
- busy bit sets the cycle after acceptance. It clears the cycle after the entry is popped or killed.
- Outputs reset values: reg_write_en=0, reg_write_dest=0, reg_write_data=0, busy=0, ld_ready=0 while rst_n=0 and 1 the cycle after release.

## Configuration
- GPR_WB_ZERO_REG_EN defined:
  - register 0 is hardwired zero; ALU dest 0 produces no write and kills nothing
  - load dest 0 is accepted (handshake completes) but not enqueued; busy[0] stays 0
- Undefined: register 0 is an ordinary register; no special-casing.

## Test plan
- Reset: hold rst_n=0 with alu_valid=1 -> reg_write_en=0, busy=0, ld_ready=0. Release -> ld_ready=1 next cycle.
- ALU only: alu_valid, dest 3, data 0x1234 at N -> N+1 reg_write_en=1, dest 3, data 0x1234. Idle N+2 -> reg_write_en=0.
- Load queue fill with ALU busy every cycle:
  - 2 loads (dest 1, 2) accepted -> ld_ready=0, busy=0x06
  - ALU stops -> writes r1 then r2 on consecutive cycles; ld_ready returns 1
- WAW kill: load dest 5, data 0xAAAA queued; ALU dest 5, data 0x5555 next cycle -> only 0x5555 written to r5; busy[5] clears; dead entry popped with no write.
- Same-cycle: load dest 4 and ALU dest 4 both at N -> ALU value written at N+1; load never written.
- Macro GPR_WB_ZERO_REG_EN: ALU dest 0 and load dest 0 -> no reg_write_en, busy[0]=0. Without macro: both written, ALU first.
